// File: rtl/aes_pkg.sv
// Shared types for the AES encryptor front end: block width, block type and
// the ATD receiver assembly states.
package aes_pkg;
  localparam int BLOCK_W = 128;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    STALL
  } atd_rx_state_e;
endpackage

// File: rtl/atd_block_receiver_sync_edge_detect.sv
// Brings the asynchronous ATD bit clock and data into clk and emits a registered
// one-cycle strobe with the data bit that was present on each ATD_clk rising edge.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic atd_clk,
  input  logic atd_data,
  output logic bit_vld_p1,
  output logic bit_val_p1
);
  logic [SYNC_STAGES-1:0] clk_sync_p0;
  logic [SYNC_STAGES-1:0] data_sync_p0;
  logic                   clk_prev_p0;

  // Synchronisers preset to the idle-high line state so reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_p0  <= '1;
      data_sync_p0 <= '1;
      clk_prev_p0  <= 1'b1;
      bit_vld_p1   <= 1'b0;
      bit_val_p1   <= 1'b0;
    end else begin
      clk_sync_p0  <= {clk_sync_p0[SYNC_STAGES-2:0], atd_clk};
      data_sync_p0 <= {data_sync_p0[SYNC_STAGES-2:0], atd_data};
      clk_prev_p0  <= clk_sync_p0[SYNC_STAGES-1];
      // ---- stage p1: edge strobe and its aligned data bit ----
      bit_vld_p1   <= clk_sync_p0[SYNC_STAGES-1] & ~clk_prev_p0;
      bit_val_p1   <= data_sync_p0[SYNC_STAGES-1];
    end
  end
endmodule

// File: rtl/atd_block_receiver.sv
// ATD serial link deserialiser: assembles 128-bit plaintext blocks (first bit received
// lands in bit 0) and hands them to the AES core over valid/ready, with one block of slack.
import aes_pkg::*;

module atd_block_receiver #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ATD_data,
  input  logic         ATD_clk,
  output block_t       block_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic [6:0]   bit_count,
  output logic         overrun,
  output logic         frame_err
);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  function automatic logic [IDLE_W-1:0] idle_sat_inc(input logic [IDLE_W-1:0] v);
    return (v == IDLE_W'(IDLE_TIMEOUT)) ? v : v + 1'b1;
  endfunction

  logic               cap_vld_p1;
  logic               cap_bit_p1;
  atd_rx_state_e      state;
  block_t             shreg;
  block_t             shreg_nxt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               out_free;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .atd_clk    (ATD_clk),
    .atd_data   (ATD_data),
    .bit_vld_p1 (cap_vld_p1),
    .bit_val_p1 (cap_bit_p1)
  );

  assign shreg_nxt = {cap_bit_p1, shreg[BLOCK_W-1:1]};
  // Output register can take a new block this edge: empty, or being accepted now.
  assign out_free  = !block_valid || block_ready;

  // ---- stage p2: assembly FSM, output buffer and status ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      shreg       <= '0;
      block_out   <= '0;
      block_valid <= 1'b0;
      bit_count   <= '0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      frame_err <= 1'b0;
      if (block_valid && block_ready)
        block_valid <= 1'b0;

      case (state)
        EMPTY: begin
          if (cap_vld_p1) begin
            shreg     <= shreg_nxt;
            bit_count <= 7'd1;
            idle_cnt  <= '0;
            state     <= FILLING;
          end
        end

        FILLING: begin
          if (cap_vld_p1) begin
            shreg    <= shreg_nxt;
            idle_cnt <= '0;
            if (bit_count == 7'(BLOCK_W - 1)) begin
              bit_count <= '0;
              if (out_free) begin
                block_out   <= shreg_nxt;
                block_valid <= 1'b1;
                shreg       <= '0;
                state       <= EMPTY;
              end else begin
                state <= STALL;
              end
            end else begin
              bit_count <= bit_count + 7'd1;
            end
          end else if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
            // Link went quiet mid-block: throw the partial block away.
            shreg     <= '0;
            bit_count <= '0;
            idle_cnt  <= '0;
            frame_err <= 1'b1;
            state     <= EMPTY;
          end else begin
            idle_cnt <= idle_sat_inc(idle_cnt);
          end
        end

        STALL: begin
          if (cap_vld_p1)
            overrun <= 1'b1;
          if (out_free) begin
            block_out   <= shreg;
            block_valid <= 1'b1;
            shreg       <= '0;
            state       <= EMPTY;
          end
        end

        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_atd_block_receiver.sv
// Bench for atd_block_receiver: drives the ATD link bit by bit and scoreboards every
// accepted block against the list of blocks that were sent whole.
module tb_atd_block_receiver;
  import aes_pkg::*;

  localparam int S  = 2;
  localparam int TO = 64;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       ATD_data = 1'b1;
  logic       ATD_clk = 1'b1;
  logic       block_ready = 1'b1;
  block_t     block_out;
  logic       block_valid;
  logic [6:0] bit_count;
  logic       overrun;
  logic       frame_err;

  always #5 tb_clk = ~tb_clk;

  atd_block_receiver #(
    .SYNC_STAGES  (S),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .clk         (tb_clk),
    .rst         (rst),
    .ATD_data    (ATD_data),
    .ATD_clk     (ATD_clk),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .bit_count   (bit_count),
    .overrun     (overrun),
    .frame_err   (frame_err)
  );

  int     cyc = 0;
  always @(posedge tb_clk) cyc <= cyc + 1;

  int     n_chk = 0;
  int     n_pass = 0;
  block_t exp_q[$];
  int     rise_cyc = 0;
  int     vld_rise_cyc = 0;
  int     vld_run = 0;
  int     ferr_cnt = 0;
  int     ferr_cyc = 0;
  block_t rise_blk = '0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, got, exp);
  endtask

  // One ATD bit: 8 clk low, rise, 8 clk high.
  task automatic send_bit(input logic b);
    #1;
    ATD_data = b;
    ATD_clk  = 1'b0;
    repeat (8) @(posedge tb_clk);
    #1;
    ATD_clk  = 1'b1;
    rise_cyc = cyc;
    repeat (8) @(posedge tb_clk);
  endtask

  task automatic send_block(input block_t blk, input bit push);
    if (push) exp_q.push_back(blk);
    for (int i = 0; i < BLOCK_W; i++) send_bit(blk[i]);
  endtask

  task automatic set_ready(input logic v);
    @(posedge tb_clk);
    #1;
    block_ready = v;
  endtask

  // Compare process: scoreboard on every handshake, hold-stability while stalled.
  initial begin
    logic   pv = 1'b0;
    logic   hold = 1'b0;
    block_t hold_out = '0;
    forever begin
      @(negedge tb_clk);
      if (rst) begin
        pv   = 1'b0;
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", block_valid, 1);
          chk("hold_stable", block_out, hold_out);
        end
        if (block_valid && !pv) begin
          vld_rise_cyc = cyc;
          rise_blk     = block_out;
          vld_run      = 0;
        end
        if (block_valid) vld_run++;
        pv = block_valid;
        if (frame_err) begin
          ferr_cnt++;
          ferr_cyc = cyc;
        end
        if (block_valid && block_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_block: got %h required none", block_out);
          end else begin
            chk("block_data", block_out, exp_q.pop_front());
          end
        end
        hold     = block_valid && !block_ready;
        hold_out = block_out;
      end
    end
  end

  initial begin
    block_t a, b, c, p, q, r, part;
    int     f0, v0;

    // Reset state
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk);
    chk("rst_valid", block_valid, 0);
    chk("rst_out", block_out, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    @(posedge tb_clk);
    #1 rst = 1'b0;

    // 1: single block, ready high
    send_block(128'h1234567890abcdef1234567890abcdef, 1);
    @(negedge tb_clk);
    chk("t1_block", rise_blk, 128'h1234567890abcdef1234567890abcdef);
    chk("t1_latency", vld_rise_cyc - rise_cyc, S + 2);
    chk("t1_pulse_len", vld_run, 1);
    chk("t1_overrun", overrun, 0);

    // 2: backpressure, stall and overrun
    set_ready(1'b0);
    a = 128'habc123abc123123abcdef32148394203;
    b = 128'h4729abe64f528ac67dbe8ac92db2631c;
    send_block(a, 1);
    send_block(b, 1);
    @(negedge tb_clk);
    chk("t2_held_out", block_out, a);
    chk("t2_held_valid", block_valid, 1);
    chk("t2_bit_count", bit_count, 0);
    c = 128'h34;
    for (int i = 0; i < 8; i++) send_bit(c[i]);
    @(negedge tb_clk);
    chk("t2_overrun", overrun, 1);
    chk("t2_stall_bit_count", bit_count, 0);
    set_ready(1'b1);
    @(negedge tb_clk);
    chk("t2_first_valid", block_valid, 1);
    chk("t2_first_out", block_out, a);
    @(negedge tb_clk);
    chk("t2_second_valid", block_valid, 1);
    chk("t2_second_out", block_out, b);
    @(negedge tb_clk);
    chk("t2_valid_drop", block_valid, 0);
    c = {$urandom, $urandom, $urandom, $urandom};
    send_block(c, 1);

    // 3: partial block timeout, then a clean block
    part = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 40; i++) send_bit(part[i]);
    @(negedge tb_clk);
    chk("t3_bit_count", bit_count, 40);
    f0 = ferr_cnt;
    repeat (100) @(posedge tb_clk);
    @(negedge tb_clk);
    chk("t3_ferr_count", ferr_cnt - f0, 1);
    chk("t3_ferr_time", ferr_cyc - rise_cyc, S + 2 + TO);
    chk("t3_bit_count_clr", bit_count, 0);
    send_block(128'h1712419abed81821378dabce998af893, 1);
    @(negedge tb_clk);
    chk("t3_block", rise_blk, 128'h1712419abed81821378dabce998af893);

    // 4: reset mid-block
    part = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 64; i++) send_bit(part[i]);
    @(negedge tb_clk);
    chk("t4_bit_count", bit_count, 64);
    @(posedge tb_clk);
    #1 rst = 1'b1;
    @(posedge tb_clk);
    #1 rst = 1'b0;
    @(negedge tb_clk);
    chk("t4_out", block_out, 0);
    chk("t4_valid", block_valid, 0);
    chk("t4_bit_count_clr", bit_count, 0);
    chk("t4_overrun_clr", overrun, 0);
    chk("t4_frame_err", frame_err, 0);
    send_block({$urandom, $urandom, $urandom, $urandom}, 1);

    // 5: ready pulsed exactly on the completion edge
    set_ready(1'b0);
    p = {$urandom, $urandom, $urandom, $urandom};
    q = {$urandom, $urandom, $urandom, $urandom};
    send_block(p, 1);
    v0 = vld_rise_cyc;
    exp_q.push_back(q);
    for (int i = 0; i < BLOCK_W - 1; i++) send_bit(q[i]);
    #1;
    ATD_data = q[BLOCK_W-1];
    ATD_clk  = 1'b0;
    repeat (8) @(posedge tb_clk);
    #1;
    ATD_clk  = 1'b1;
    rise_cyc = cyc;
    repeat (S + 1) @(posedge tb_clk);
    #1 block_ready = 1'b1;
    @(negedge tb_clk);
    chk("t5_before_out", block_out, p);
    @(posedge tb_clk);
    #1 block_ready = 1'b0;
    @(negedge tb_clk);
    chk("t5_after_valid", block_valid, 1);
    chk("t5_after_out", block_out, q);
    chk("t5_continuous", vld_rise_cyc, v0);
    chk("t5_overrun", overrun, 0);
    set_ready(1'b1);
    r = {$urandom, $urandom, $urandom, $urandom};
    send_block(r, 1);

    // Random blocks under random ready
    fork
      begin
        for (int k = 0; k < 3; k++) send_block({$urandom, $urandom, $urandom, $urandom}, 1);
      end
      begin
        repeat (3 * BLOCK_W * 16 + 40) begin
          @(posedge tb_clk);
          #1 block_ready = 1'($urandom_range(0, 1));
        end
        block_ready = 1'b1;
      end
    join

    repeat (50) @(posedge tb_clk);
    @(negedge tb_clk);
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_valid", block_valid, 0);
    chk("end_overrun", overrun, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
